// File: rtl/test_rtl_dma_pkg.sv
// rtl/test_rtl_dma_pkg.sv - shared constants and state encoding for the 64-bit DMA memory responder
package test_rtl_dma_pkg;

    localparam logic [2:0] DMA_SIZE_64 = 3'b011;
    localparam int         DMA_DATA_W  = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } dma_state_t;

endpackage

// File: rtl/dma64_dp_ram.sv
// rtl/dma64_dp_ram.sv - two-port read-first word RAM (burst port A, backdoor port B)
module dma64_dp_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = 10,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic [DW-1:0] b_rdata
);

    logic [DW-1:0] mem [WORDS];

    // Array writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
    end

    // Read-first output registers: a same-cycle write is seen on the next read only.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= mem[a_addr];
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/test_rtl_dma64_mem_responder.sv
// rtl/test_rtl_dma64_mem_responder.sv - DMA read/write channel responder backed by a 64-bit word memory
module test_rtl_dma64_mem_responder
    import test_rtl_dma_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dma_read_ctrl_valid,
    output logic                  dma_read_ctrl_ready,
    input  logic [31:0]           dma_read_ctrl_data_index,
    input  logic [31:0]           dma_read_ctrl_data_length,
    input  logic [2:0]            dma_read_ctrl_data_size,
    input  logic [5:0]            dma_read_ctrl_data_user,
    output logic                  dma_read_chnl_valid,
    input  logic                  dma_read_chnl_ready,
    output logic [DMA_DATA_W-1:0] dma_read_chnl_data,
    input  logic                  dma_write_ctrl_valid,
    output logic                  dma_write_ctrl_ready,
    input  logic [31:0]           dma_write_ctrl_data_index,
    input  logic [31:0]           dma_write_ctrl_data_length,
    input  logic [2:0]            dma_write_ctrl_data_size,
    input  logic [5:0]            dma_write_ctrl_data_user,
    input  logic                  dma_write_chnl_valid,
    output logic                  dma_write_chnl_ready,
    input  logic [DMA_DATA_W-1:0] dma_write_chnl_data,
    input  logic                  bd_we,
    input  logic [ADDR_W-1:0]     bd_addr,
    input  logic [DMA_DATA_W-1:0] bd_wdata,
    output logic [DMA_DATA_W-1:0] bd_rdata,
    output logic                  rd_done,
    output logic                  wr_done,
    output logic                  size_err,
    output logic [31:0]           debug
);

    dma_state_t state_q, state_d;

    logic [ADDR_W-1:0]     base_q;
    logic [31:0]           len_q, issue_cnt_q, beat_cnt_q;
    logic                  pend_q, out_valid_q, skid_valid_q;
    logic [DMA_DATA_W-1:0] out_data_q, skid_data_q;
    logic                  rd_done_q, wr_done_q, size_err_q;

    logic                  idle, rd_accept, wr_accept, consume, last_rd, wr_hs, last_wr;
    logic                  issue_rd, first_issue;
    logic [1:0]            occ;
    logic                  ram_a_we;
    logic [ADDR_W-1:0]     ram_a_addr;
    logic [DMA_DATA_W-1:0] ram_a_rdata;
    logic                  unused_bits;

    assign unused_bits = ^{dma_read_ctrl_data_user, dma_write_ctrl_data_user,
                           dma_read_ctrl_data_index[31:ADDR_W], dma_write_ctrl_data_index[31:ADDR_W]};

    assign idle                 = (state_q == IDLE);
    assign dma_read_ctrl_ready  = idle && !rst;
    assign dma_write_ctrl_ready = idle && !rst && !dma_read_ctrl_valid;
    assign dma_write_chnl_ready = (state_q == WR_BURST) && !rst;
    assign rd_accept            = dma_read_ctrl_valid && dma_read_ctrl_ready;
    assign wr_accept            = dma_write_ctrl_valid && dma_write_ctrl_ready;

    assign consume = out_valid_q && dma_read_chnl_ready;
    assign last_rd = consume && (beat_cnt_q == len_q - 32'd1);
    assign wr_hs   = dma_write_chnl_valid && dma_write_chnl_ready;
    assign last_wr = wr_hs && (beat_cnt_q == len_q - 32'd1);

    // Beats held or in flight after this edge; at most one may remain so the next
    // returning read always finds a free slot in out/skid.
    assign occ         = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(pend_q) - 2'(consume);
    assign issue_rd    = (state_q == RD_BURST) && (issue_cnt_q != len_q) && (occ <= 2'd1);
    // The first beat is fetched in the acceptance cycle so valid can appear two cycles later.
    assign first_issue = rd_accept && (dma_read_ctrl_data_length != 32'd0);
    assign ram_a_we    = wr_hs;

    // Burst-port address: ctrl index while idle, otherwise base plus the relevant counter.
    always_comb begin
        ram_a_addr = dma_read_ctrl_data_index[ADDR_W-1:0];
        if (state_q == RD_BURST) ram_a_addr = base_q + issue_cnt_q[ADDR_W-1:0];
        if (state_q == WR_BURST) ram_a_addr = base_q + beat_cnt_q[ADDR_W-1:0];
    end

    dma64_dp_ram #(.WORDS(MEM_WORDS), .AW(ADDR_W), .DW(DMA_DATA_W)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_we    (ram_a_we),
        .a_addr  (ram_a_addr),
        .a_wdata (dma_write_chnl_data),
        .a_rdata (ram_a_rdata),
        .b_we    (bd_we && idle && !rst),
        .b_addr  (bd_addr),
        .b_wdata (bd_wdata),
        .b_rdata (bd_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: zero-length requests complete without leaving IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_accept && dma_read_ctrl_data_length != 32'd0)       state_d = RD_BURST;
                else if (wr_accept && dma_write_ctrl_data_length != 32'd0) state_d = WR_BURST;
            end
            RD_BURST: if (last_rd) state_d = IDLE;
            WR_BURST: if (last_wr) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Request latching, beat counters, done pulses and the sticky size flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            pend_q      <= 1'b0;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            size_err_q  <= 1'b0;
        end else begin
            rd_done_q <= (rd_accept && dma_read_ctrl_data_length == 32'd0) || last_rd;
            wr_done_q <= (wr_accept && dma_write_ctrl_data_length == 32'd0) || last_wr;
            pend_q    <= first_issue || issue_rd;
            if (rd_accept) begin
                base_q      <= dma_read_ctrl_data_index[ADDR_W-1:0];
                len_q       <= dma_read_ctrl_data_length;
                issue_cnt_q <= first_issue ? 32'd1 : 32'd0;
                beat_cnt_q  <= '0;
                if (dma_read_ctrl_data_size != DMA_SIZE_64) size_err_q <= 1'b1;
            end else if (wr_accept) begin
                base_q      <= dma_write_ctrl_data_index[ADDR_W-1:0];
                len_q       <= dma_write_ctrl_data_length;
                issue_cnt_q <= '0;
                beat_cnt_q  <= '0;
                if (dma_write_ctrl_data_size != DMA_SIZE_64) size_err_q <= 1'b1;
            end else begin
                if (issue_rd)         issue_cnt_q <= issue_cnt_q + 32'd1;
                if (consume || wr_hs) beat_cnt_q  <= beat_cnt_q + 32'd1;
            end
        end
    end

    // Read beat output register with a one-entry skid buffer behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (consume || !out_valid_q) begin
            if (skid_valid_q) begin
                out_data_q  <= skid_data_q;
                out_valid_q <= 1'b1;
                if (pend_q) skid_data_q  <= ram_a_rdata;
                else        skid_valid_q <= 1'b0;
            end else if (pend_q) begin
                out_data_q  <= ram_a_rdata;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (pend_q) begin
            skid_data_q  <= ram_a_rdata;
            skid_valid_q <= 1'b1;
        end
    end

    assign dma_read_chnl_valid = out_valid_q;
    assign dma_read_chnl_data  = out_data_q;
    assign rd_done             = rd_done_q;
    assign wr_done             = wr_done_q;
    assign size_err            = size_err_q;
    assign debug               = {28'd0, 2'd0, state_q};

endmodule

// File: tb/tb_test_rtl_dma64_mem_responder.sv
// tb/tb_test_rtl_dma64_mem_responder.sv - directed scoreboard bench for the DMA memory responder
module tb_test_rtl_dma64_mem_responder;

    localparam int MW = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_read_ctrl_valid, dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic [5:0]  dma_read_ctrl_data_user;
    logic        dma_read_chnl_valid, dma_read_chnl_ready;
    logic [63:0] dma_read_chnl_data;
    logic        dma_write_ctrl_valid, dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index, dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic [5:0]  dma_write_ctrl_data_user;
    logic        dma_write_chnl_valid, dma_write_chnl_ready;
    logic [63:0] dma_write_chnl_data;
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [63:0] bd_wdata, bd_rdata;
    logic        rd_done, wr_done, size_err;
    logic [31:0] debug;

    test_rtl_dma64_mem_responder #(.MEM_WORDS(MW), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
        .dma_read_ctrl_data_index(dma_read_ctrl_data_index), .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size(dma_read_ctrl_data_size), .dma_read_ctrl_data_user(dma_read_ctrl_data_user),
        .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
        .dma_read_chnl_data(dma_read_chnl_data),
        .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
        .dma_write_ctrl_data_index(dma_write_ctrl_data_index), .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size(dma_write_ctrl_data_size), .dma_write_ctrl_data_user(dma_write_ctrl_data_user),
        .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
        .dma_write_chnl_data(dma_write_chnl_data),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
        .rd_done(rd_done), .wr_done(wr_done), .size_err(size_err), .debug(debug)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc_n = 0;
    logic [63:0] model [MW];
    logic [63:0] exp_q [$];
    int          rd_acc_cyc, wr_acc_cyc, first_valid_cyc, last_beat_cyc, beats;
    int          rd_done_cnt, rd_done_cyc, wr_done_cnt, wr_done_cyc, wr_beats, last_wr_cyc, t_req;
    logic [9:0]  wr_addr;
    bit          hold_pending;
    logic [63:0] held_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Negedge observer: scoreboard pops, stall stability, write-beat model updates, done pulses.
    task automatic monitor();
        if (rst) begin
            hold_pending = 0;
        end else begin
            if (dma_read_ctrl_valid && dma_read_ctrl_ready)   rd_acc_cyc = cyc_n;
            if (dma_write_ctrl_valid && dma_write_ctrl_ready) wr_acc_cyc = cyc_n;
            if (dma_read_chnl_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc_n;
                if (hold_pending) check("rd_stall_data", dma_read_chnl_data, held_data);
                if (dma_read_chnl_ready) begin
                    check("rd_beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) check("rd_beat_data", dma_read_chnl_data, exp_q.pop_front());
                    beats++;
                    last_beat_cyc = cyc_n;
                    hold_pending = 0;
                end else begin
                    hold_pending = 1;
                    held_data = dma_read_chnl_data;
                end
            end else if (hold_pending) begin
                check("rd_stall_valid", 64'(dma_read_chnl_valid), 64'd1);
                hold_pending = 0;
            end
            if (dma_write_chnl_valid && dma_write_chnl_ready) begin
                model[wr_addr] = dma_write_chnl_data;
                wr_addr = wr_addr + 10'd1;
                wr_beats++;
                last_wr_cyc = cyc_n;
            end
            if (rd_done) begin rd_done_cnt++; rd_done_cyc = cyc_n; end
            if (wr_done) begin wr_done_cnt++; wr_done_cyc = cyc_n; end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic rd_req(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
        logic [9:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = 10'(idx + 32'(i));
            exp_q.push_back(model[a]);
        end
        rd_acc_cyc = -1; first_valid_cyc = -1; beats = 0; rd_done_cnt = 0; hold_pending = 0;
        dma_read_ctrl_valid = 1'b1;
        dma_read_ctrl_data_index = idx;
        dma_read_ctrl_data_length = len;
        dma_read_ctrl_data_size = sz;
        t_req = cyc_n;
        cyc();
        dma_read_ctrl_valid = 1'b0;
        check("rd_ctrl_accept_cycle", 64'(rd_acc_cyc), 64'(t_req));
        check("rd_state", debug, (len != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic rd_wait(input int len, input bit bp);
        int budget = 0;
        while (rd_done_cnt == 0 && budget < 400) begin
            if (bp) dma_read_chnl_ready = ~dma_read_chnl_ready;
            cyc();
            budget++;
        end
        dma_read_chnl_ready = 1'b1;
        cyc();
        cyc();
        check("rd_done_count", 64'(rd_done_cnt), 64'd1);
        check("rd_beat_count", 64'(beats), 64'(len));
        check("rd_queue_drained", 64'(exp_q.size()), 64'd0);
        check("rd_done_after_last", 64'(rd_done_cyc), 64'(last_beat_cyc + 1));
    endtask

    task automatic wr_req(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
        wr_acc_cyc = -1; wr_beats = 0; wr_done_cnt = 0; wr_addr = idx[9:0];
        dma_write_ctrl_valid = 1'b1;
        dma_write_ctrl_data_index = idx;
        dma_write_ctrl_data_length = len;
        dma_write_ctrl_data_size = sz;
        t_req = cyc_n;
        cyc();
        dma_write_ctrl_valid = 1'b0;
        check("wr_ctrl_accept_cycle", 64'(wr_acc_cyc), 64'(t_req));
        check("wr_chnl_ready_after_accept", 64'(dma_write_chnl_ready), (len != 0) ? 64'd1 : 64'd0);
        check("wr_state", debug, (len != 0) ? 32'd2 : 32'd0);
    endtask

    task automatic wr_feed(input int len, input logic [63:0] val0, input bit gaps);
        int budget = 0;
        while (wr_beats < len && budget < 400) begin
            dma_write_chnl_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            dma_write_chnl_data = val0 + 64'(wr_beats);
            cyc();
            budget++;
        end
        dma_write_chnl_valid = 1'b0;
        budget = 0;
        while (wr_done_cnt == 0 && budget < 20) begin cyc(); budget++; end
        cyc();
        cyc();
        check("wr_beat_count", 64'(wr_beats), 64'(len));
        check("wr_done_count", 64'(wr_done_cnt), 64'd1);
        check("wr_done_after_last", 64'(wr_done_cyc), 64'(last_wr_cyc + 1));
    endtask

    task automatic bd_check(input logic [9:0] addr, input logic [63:0] exp);
        bd_addr = addr;
        cyc();
        check("bd_rdata", bd_rdata, exp);
    endtask

    initial begin
        rst = 1'b1;
        dma_read_ctrl_valid = 0; dma_read_ctrl_data_index = 0; dma_read_ctrl_data_length = 0;
        dma_read_ctrl_data_size = 3'b011; dma_read_ctrl_data_user = 0; dma_read_chnl_ready = 1'b1;
        dma_write_ctrl_valid = 0; dma_write_ctrl_data_index = 0; dma_write_ctrl_data_length = 0;
        dma_write_ctrl_data_size = 3'b011; dma_write_ctrl_data_user = 0;
        dma_write_chnl_valid = 0; dma_write_chnl_data = 0;
        bd_we = 0; bd_addr = 0; bd_wdata = 0;
        wr_addr = 0; wr_beats = 0; rd_done_cnt = 0; wr_done_cnt = 0; beats = 0;
        first_valid_cyc = -1; last_beat_cyc = 0; last_wr_cyc = 0; rd_done_cyc = 0; wr_done_cyc = 0;
        hold_pending = 0; held_data = 0;
        repeat (3) cyc();

        // Reset state
        check("rst_rd_ctrl_ready", 64'(dma_read_ctrl_ready), 64'd0);
        check("rst_wr_ctrl_ready", 64'(dma_write_ctrl_ready), 64'd0);
        check("rst_wr_chnl_ready", 64'(dma_write_chnl_ready), 64'd0);
        check("rst_rd_valid", 64'(dma_read_chnl_valid), 64'd0);
        check("rst_rd_data", dma_read_chnl_data, 64'd0);
        check("rst_bd_rdata", bd_rdata, 64'd0);
        check("rst_done", 64'({rd_done, wr_done}), 64'd0);
        check("rst_size_err", 64'(size_err), 64'd0);
        check("rst_debug", debug, 32'd0);
        rst = 1'b0;
        cyc();
        check("idle_rd_ctrl_ready", 64'(dma_read_ctrl_ready), 64'd1);

        // Backdoor preload
        bd_we = 1'b1;
        for (int i = 0; i < 128; i++) begin
            bd_addr = 10'(i); bd_wdata = 64'(i); model[i] = 64'(i);
            cyc();
        end
        bd_addr = 10'd1022; bd_wdata = 64'hAAAA_0000_0000_03FE; model[1022] = bd_wdata; cyc();
        bd_addr = 10'd1023; bd_wdata = 64'hAAAA_0000_0000_03FF; model[1023] = bd_wdata; cyc();
        bd_we = 1'b0;
        bd_check(10'd5, 64'd5);
        bd_check(10'd1023, 64'hAAAA_0000_0000_03FF);

        // Read, no backpressure
        dma_read_chnl_ready = 1'b1;
        rd_req(0, 16, 3'b011);
        rd_wait(16, 0);
        check("rd_first_valid_latency", 64'(first_valid_cyc), 64'(t_req + 2));
        check("rd_no_bubbles", 64'(last_beat_cyc - first_valid_cyc), 64'd15);

        // Read with backpressure; a backdoor write mid-burst must be ignored
        dma_read_chnl_ready = 1'b0;
        rd_req(0, 16, 3'b011);
        bd_we = 1'b1; bd_addr = 10'd100; bd_wdata = 64'hDEAD;
        cyc();
        bd_we = 1'b0;
        rd_wait(16, 1);
        bd_check(10'd100, 64'd100);

        // Idle write channel does not accept beats
        dma_write_chnl_valid = 1'b1; dma_write_chnl_data = 64'hBAD;
        cyc();
        check("idle_wr_chnl_ready", 64'(dma_write_chnl_ready), 64'd0);
        check("idle_wr_no_beat", 64'(wr_beats), 64'd0);
        dma_write_chnl_valid = 1'b0;

        // Write with random valid gaps, then inspect
        wr_req(32, 16, 3'b011);
        wr_feed(16, 64'h100, 1);
        for (int i = 0; i < 16; i++) bd_check(10'(32 + i), 64'h100 + 64'(i));

        // Contention: read wins, write accepted when the read burst reports done
        for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
        rd_acc_cyc = -1; wr_acc_cyc = -1; first_valid_cyc = -1; beats = 0; rd_done_cnt = 0;
        wr_beats = 0; wr_done_cnt = 0; wr_addr = 10'd64;
        dma_read_ctrl_valid = 1'b1; dma_read_ctrl_data_index = 0; dma_read_ctrl_data_length = 4;
        dma_write_ctrl_valid = 1'b1; dma_write_ctrl_data_index = 64; dma_write_ctrl_data_length = 2;
        t_req = cyc_n;
        cyc();
        dma_read_ctrl_valid = 1'b0;
        check("cont_rd_first", 64'(rd_acc_cyc), 64'(t_req));
        check("cont_wr_pending", 64'(wr_acc_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        for (int b = 0; b < 40 && wr_acc_cyc < 0; b++) cyc();
        dma_write_ctrl_valid = 1'b0;
        check("cont_wr_at_rd_done", 64'(wr_acc_cyc), 64'(rd_done_cyc));
        check("cont_rd_beats", 64'(beats), 64'd4);
        wr_feed(2, 64'h200, 0);
        bd_check(10'd64, 64'h200);
        bd_check(10'd65, 64'h201);

        // Address wrap
        rd_req(MW - 2, 4, 3'b011);
        rd_wait(4, 0);

        // Zero-length requests
        rd_req(5, 0, 3'b011);
        check("len0_rd_done_t1", 64'(rd_done), 64'd1);
        cyc();
        check("len0_rd_done_single", 64'(rd_done), 64'd0);
        check("len0_rd_no_beats", 64'(first_valid_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        wr_req(7, 0, 3'b011);
        check("len0_wr_done_t1", 64'(wr_done), 64'd1);
        cyc();
        check("len0_wr_done_single", 64'(wr_done), 64'd0);

        // Size error is sticky; the request is still served as 64-bit
        check("size_err_before", 64'(size_err), 64'd0);
        rd_req(10, 2, 3'b010);
        check("size_err_set", 64'(size_err), 64'd1);
        rd_wait(2, 0);
        check("size_err_sticky", 64'(size_err), 64'd1);

        // Reset at read beat 5
        rd_req(0, 16, 3'b011);
        for (int b = 0; b < 40 && beats < 5; b++) cyc();
        rst = 1'b1;
        cyc();
        check("rstmid_valid", 64'(dma_read_chnl_valid), 64'd0);
        check("rstmid_debug", debug, 32'd0);
        check("rstmid_size_err", 64'(size_err), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        cyc();
        check("rstmid_no_done", 64'(rd_done_cnt), 64'd0);
        for (int i = 0; i < 4; i++) bd_check(10'(i), 64'(i));
        bd_check(10'd47, 64'h10F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
